// File: rtl/vidac_enc.sv
// rtl/vidac_enc.sv - vidac command-list encoder; optional bounding-box culling via VIDAC_ENC_CULL_EN
module vidac_enc #(
  parameter logic [17:0] BASE     = 18'h20000,
  parameter int          MAX_CMDS = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_code,
  input  logic [15:0] cmd_x1,
  input  logic [15:0] cmd_y1,
  input  logic [15:0] cmd_x2,
  input  logic [15:0] cmd_y2,
  input  logic [7:0]  cmd_color,
  input  logic        flush,
  output logic        done,
  output logic [17:0] a,
  output logic [7:0]  o,
  output logic        w,
  output logic        own,
  output logic        kick,
  input  logic        bsy
);

  localparam int CW = $clog2(MAX_CMDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_CMDS - 1);

  // The full list plus terminator must stay inside the 18-bit address space.
  generate
    if (int'(BASE) + 10 * MAX_CMDS >= (1 << 18)) begin : g_range_check
      $error("vidac_enc: BASE + 10*MAX_CMDS exceeds the 18-bit address space");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_KICK,
    S_WAITHI,
    S_WAITLO
  } state_t;

  state_t        state;
  logic [17:0]   ptr;
  logic [CW-1:0] count;
  logic          pending;
  logic [3:0]    k;
  logic [1:0]    l_code;
  logic [15:0]   l_x1, l_y1, l_x2, l_y2;
  logic [7:0]    l_color;
  logic          culled;

`ifdef VIDAC_ENC_CULL_EN
  logic signed [15:0] xmin, xmax, ymin, ymax;

  // Signed bounding box of the presented request against the 320x200 screen.
  always_comb begin
    xmin   = ($signed(cmd_x1) < $signed(cmd_x2)) ? $signed(cmd_x1) : $signed(cmd_x2);
    xmax   = ($signed(cmd_x1) < $signed(cmd_x2)) ? $signed(cmd_x2) : $signed(cmd_x1);
    ymin   = ($signed(cmd_y1) < $signed(cmd_y2)) ? $signed(cmd_y1) : $signed(cmd_y2);
    ymax   = ($signed(cmd_y1) < $signed(cmd_y2)) ? $signed(cmd_y2) : $signed(cmd_y1);
    culled = (xmax < 16'sd0) || (xmin > 16'sd319) || (ymax < 16'sd0) || (ymin > 16'sd199);
  end
`else
  assign culled = 1'b0;
`endif

  // Byte k of the latched command in list order; index 10 is the terminator.
  function automatic logic [7:0] byte_sel(input logic [3:0] idx);
    case (idx)
      4'd0:    byte_sel = {6'd0, l_code};
      4'd1:    byte_sel = l_x1[7:0];
      4'd2:    byte_sel = l_x1[15:8];
      4'd3:    byte_sel = l_y1[7:0];
      4'd4:    byte_sel = l_y1[15:8];
      4'd5:    byte_sel = l_x2[7:0];
      4'd6:    byte_sel = l_x2[15:8];
      4'd7:    byte_sel = l_y2[7:0];
      4'd8:    byte_sel = l_y2[15:8];
      4'd9:    byte_sel = l_color;
      default: byte_sel = 8'h00;
    endcase
  endfunction

  // Encoder FSM: serialise commands, append the terminator, then kick vidac and track bsy.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ptr       <= BASE;
      count     <= '0;
      pending   <= 1'b0;
      k         <= '0;
      l_code    <= '0;
      l_x1      <= '0;
      l_y1      <= '0;
      l_x2      <= '0;
      l_y2      <= '0;
      l_color   <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      a         <= BASE;
      o         <= '0;
      w         <= 1'b0;
      own       <= 1'b1;
      kick      <= 1'b0;
    end else begin
      done <= 1'b0;
      kick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_code != 2'd0 && !culled) begin
            l_code    <= cmd_code;
            l_x1      <= cmd_x1;
            l_y1      <= cmd_y1;
            l_x2      <= cmd_x2;
            l_y2      <= cmd_y2;
            l_color   <= cmd_color;
            a         <= ptr;
            o         <= {6'd0, cmd_code};
            w         <= 1'b1;
            k         <= 4'd1;
            cmd_ready <= 1'b0;
            // A flush arriving with the command is honoured after the write.
            pending   <= pending | flush;
            state     <= S_WRITE;
          end else if (flush || pending) begin
            pending <= 1'b0;
            if (count != '0) begin
              kick      <= 1'b1;
              own       <= 1'b0;
              cmd_ready <= 1'b0;
              state     <= S_KICK;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (flush) pending <= 1'b1;
          if (k != 4'd11) begin
            a <= ptr + 18'(k);
            o <= byte_sel(k);
            w <= 1'b1;
            k <= k + 4'd1;
          end else begin
            w     <= 1'b0;
            o     <= '0;
            ptr   <= ptr + 18'd10;
            count <= count + 1'b1;
            if (count == LAST_CNT || pending || flush) begin
              pending <= 1'b0;
              kick    <= 1'b1;
              own     <= 1'b0;
              state   <= S_KICK;
            end else begin
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_KICK: begin
          if (flush) pending <= 1'b1;
          // bsy already high here counts as the rise.
          state <= bsy ? S_WAITLO : S_WAITHI;
        end
        S_WAITHI: begin
          if (flush) pending <= 1'b1;
          if (bsy) state <= S_WAITLO;
        end
        S_WAITLO: begin
          if (flush) pending <= 1'b1;
          if (!bsy) begin
            ptr       <= BASE;
            count     <= '0;
            a         <= BASE;
            done      <= 1'b1;
            own       <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vidac_enc.sv
// tb/tb_vidac_enc.sv - scoreboard bench for vidac_enc with a behavioural vidac bsy model
module tb_vidac_enc;

  localparam logic [17:0] BASE = 18'h20000;
  localparam int MAXC = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_code;
  logic [15:0] cmd_x1, cmd_y1, cmd_x2, cmd_y2;
  logic [7:0]  cmd_color;
  logic        flush;
  logic        done;
  logic [17:0] a;
  logic [7:0]  o;
  logic        w;
  logic        own;
  logic        kick;
  logic        bsy;

  vidac_enc #(.BASE(BASE), .MAX_CMDS(MAXC)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
    .cmd_color(cmd_color), .flush(flush), .done(done),
    .a(a), .o(o), .w(w), .own(own), .kick(kick), .bsy(bsy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bsy_len = 4;
  int nwrites = 0;
  int nkicks = 0;
  int kick_cyc = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  logic [17:0] exp_wa[$];
  logic [7:0]  exp_wd[$];
  byte         exp_ev[$];
  logic [7:0]  mem [0:255];
  logic [17:0] exp_ptr;
  int          exp_count;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // vidac model: bsy rises on the edge after kick and stays high bsy_len edges.
  initial begin
    bsy = 1'b0;
    forever begin
      @(negedge clock);
      if (kick === 1'b1) begin
        @(posedge clock);
        #1 bsy = 1'b1;
        repeat (bsy_len) @(posedge clock);
        #1 bsy = 1'b0;
      end
    end
  end

  // Monitor: pops expected writes/events whenever the DUT presents them.
  always @(negedge clock) begin
    if (w === 1'b1) begin
      nwrites++;
      chk("own_during_write", 32'(own), 32'd1);
      if (exp_wa.size() == 0) begin
        chk("unexpected_write_addr", 32'(a), 32'h3ffff);
      end else begin
        chk("write_addr", 32'(a), 32'(exp_wa.pop_front()));
        chk("write_data", 32'(o), 32'(exp_wd.pop_front()));
      end
      if (a >= BASE && a < BASE + 18'd256) mem[8'(a - BASE)] = o;
    end
    if (kick === 1'b1) begin
      nkicks++;
      kick_cyc = cyc;
      if (exp_ev.size() == 0) chk("unexpected_kick", 32'd1, 32'd0);
      else chk("event_kick", 32'(exp_ev.pop_front()), 32'("K"));
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
      if (exp_ev.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("event_done", 32'(exp_ev.pop_front()), 32'("D"));
    end
  end

  task automatic push_list_end(input bit kicked);
    if (kicked) exp_ev.push_back("K");
    exp_ev.push_back("D");
    exp_ptr = BASE;
    exp_count = 0;
  endtask

  task automatic send_cmd(input logic [1:0] code, input logic [15:0] x1, input logic [15:0] y1,
                          input logic [15:0] x2, input logic [15:0] y2, input logic [7:0] c,
                          input bit written);
    logic [7:0] b[11];
    int n = 0;
    @(negedge clock);
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (cmd_ready !== 1'b1) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_code = code; cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2; cmd_color = c;
    cmd_valid = 1'b1;
    if (written) begin
      b = '{{6'd0, code}, x1[7:0], x1[15:8], y1[7:0], y1[15:8],
            x2[7:0], x2[15:8], y2[7:0], y2[15:8], c, 8'h00};
      for (int i = 0; i < 11; i++) begin
        exp_wa.push_back(exp_ptr + 18'(i));
        exp_wd.push_back(b[i]);
      end
      exp_ptr += 18'd10;
      exp_count++;
      if (exp_count == MAXC) push_list_end(1'b1);
    end
    @(posedge clock);
    acc_cyc = cyc;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clock);
    flush = 1'b1;
    push_list_end(exp_count > 0);
    @(posedge clock);
    #1 flush = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_ev.size() != 0 || exp_wa.size() != 0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(exp_ev.size() + exp_wa.size()), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_a"}, 32'(a), 32'(BASE));
    chk({tag, "_o"}, 32'(o), 32'd0);
    chk({tag, "_w"}, 32'(w), 32'd0);
    chk({tag, "_own"}, 32'(own), 32'd1);
    chk({tag, "_kick"}, 32'(kick), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] line_ref[11];
    int a1, a2, a3, wsave, ksave;
    line_ref = '{8'h01, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h64, 8'h00, 8'h32, 8'h00, 8'h0F, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    exp_ptr = BASE; exp_count = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0; cmd_code = '0;
    cmd_x1 = '0; cmd_y1 = '0; cmd_x2 = '0; cmd_y2 = '0; cmd_color = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Line write then flush.
    send_cmd(2'd1, 16'd10, 16'd20, 16'd100, 16'd50, 8'h0F, 1'b1);
    do_flush();
    wait_quiet("line_drain");
    for (int i = 0; i < 11; i++) chk($sformatf("line_mem_%0d", i), 32'(mem[i]), 32'(line_ref[i]));
    chk("line_kicks", 32'(nkicks), 32'd1);
    chk("line_done_latency", 32'(done_cyc - kick_cyc), 32'(bsy_len + 2));

    // Back-to-back: 12 cycles between acceptances.
    send_cmd(2'd2, 16'd1, 16'd2, 16'd3, 16'd4, 8'h11, 1'b1); a1 = acc_cyc;
    send_cmd(2'd3, 16'hFFFB, 16'd6, 16'd300, 16'd199, 8'h22, 1'b1); a2 = acc_cyc;
    send_cmd(2'd1, 16'd7, 16'd8, 16'd9, 16'd10, 8'h33, 1'b1); a3 = acc_cyc;
    chk("b2b_gap1", 32'(a2 - a1), 32'd12);
    chk("b2b_gap2", 32'(a3 - a2), 32'd12);
    do_flush();
    wait_quiet("b2b_drain");
    chk("b2b_term", 32'(mem[8'h1E]), 32'h00);
    chk("b2b_third_code", 32'(mem[8'h14]), 32'h01);

    // Auto-flush on full, then a command lands back at BASE.
    for (int i = 0; i < MAXC; i++)
      send_cmd(2'd3, 16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3), 8'(8'h40 + i), 1'b1);
    wait_quiet("full_drain");
    chk("full_term", 32'(mem[8'hA0]), 32'h00);
    chk("full_kicks", 32'(nkicks), 32'd3);
    send_cmd(2'd2, 16'd50, 16'd60, 16'd70, 16'd80, 8'h5A, 1'b1);
    do_flush();
    wait_quiet("after_full_drain");

    // Empty flush and illegal code: done only, no kick, no writes.
    wsave = nwrites; ksave = nkicks;
    do_flush();
    send_cmd(2'd0, 16'd1, 16'd1, 16'd2, 16'd2, 8'h77, 1'b0);
    wait_quiet("empty_drain");
    chk("empty_writes", 32'(nwrites - wsave), 32'd0);
    chk("empty_kicks", 32'(nkicks - ksave), 32'd0);

    // Flush during WRITE with a long vidac run.
    bsy_len = 500;
    send_cmd(2'd1, 16'd0, 16'd0, 16'd319, 16'd199, 8'hC3, 1'b1);
    repeat (3) @(negedge clock);
    do_flush();
    wait_quiet("fdw_drain");
    chk("fdw_done_latency", 32'(done_cyc - kick_cyc), 32'd502);
    bsy_len = 4;

    // Culling candidate: off-screen block.
    wsave = nwrites;
`ifdef VIDAC_ENC_CULL_EN
    send_cmd(2'd3, 16'd400, 16'd10, 16'd500, 16'd20, 8'h99, 1'b0);
    wait_quiet("cull_drain");
    chk("cull_writes", 32'(nwrites - wsave), 32'd0);
`else
    send_cmd(2'd3, 16'd400, 16'd10, 16'd500, 16'd20, 8'h99, 1'b1);
    wait_quiet("cull_drain");
    chk("cull_writes", 32'(nwrites - wsave), 32'd11);
`endif

    // Reset mid-WRITE discards the list.
    send_cmd(2'd2, 16'd5, 16'd5, 16'd6, 16'd6, 8'h12, 1'b1);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    exp_wa.delete(); exp_wd.delete();
    exp_ptr = BASE; exp_count = 0;
    @(negedge clock);
    chk_reset_outputs("midrst");
    reset_n = 1'b1;
    send_cmd(2'd1, 16'd3, 16'd4, 16'd5, 16'd6, 8'hAB, 1'b1);
    do_flush();
    wait_quiet("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
